demux_lanes_rx: RTL

//  Receive-side counterpart of the 4-lane mux tree. Takes the serialized 9-bit word stream
//  (bit 8 = valid, bits 7:0 = payload) at the fast clock and finds lane alignment from sync words.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_lanes_rx_lane_aligner.sv | 109 ++++++++++
 rtl/demux_lanes_rx.sv | 119 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 4-lane receive demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int         LANES         = 4;
    localparam int         SLOT_W        = 2;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // An invalid word keeps the lane's previous payload but reports valid=0.
    function automatic logic [8:0] lane_word(input logic [8:0] w, input logic [7:0] prev_pay);
        return w[8] ? w : {1'b0, prev_pay};
    endfunction

endpackage

// File: rtl/demux_lanes_rx_lane_aligner.sv
// Finds quad alignment from sync words: slot counter, HUNT/VERIFY/LOCKED FSM, miss tracking.
// Latency: slot/locked are registered; err and miss_last describe the word sampled this cycle.
// Backpressure: none, consumes one word every cycle unconditionally.
module lane_aligner
    import demux_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int          LOCK_COUNT = 4,
    parameter int          MISS_LIMIT = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [8:0]        i_dat,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_locked,
    output logic              o_err,
    output logic              o_miss_last
);

    localparam logic [3:0] LC = 4'(LOCK_COUNT);
    localparam logic [3:0] ML = 4'(MISS_LIMIT);

    align_state_t      r_state;
    align_state_t      w_state_nxt;
    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [3:0]        r_miss;
    logic [3:0]        w_miss_nxt;
    logic              w_sync;
    logic              w_slot0;
    logic              w_err;
    logic              w_miss_last;
    logic [3:0]        w_cnt_inc;

    assign w_sync      = (i_dat == {1'b1, SYNC_BYTE});
    assign w_slot0     = (r_slot == '0);
    assign w_cnt_inc   = r_cnt + 4'd1;
    assign w_miss_last = (r_miss == ML - 4'd1);

    // State, slot and counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= HUNT;
            r_slot  <= '0;
            r_cnt   <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_cnt   <= w_cnt_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    // Next-state: the slot free-runs except when HUNT realigns it on a sync word.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot + 2'd1;
        w_cnt_nxt   = r_cnt;
        w_miss_nxt  = r_miss;
        w_err       = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_sync) begin
                    w_slot_nxt  = 2'd1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = VERIFY;
                end
            end
            VERIFY: begin
                if (w_slot0) begin
                    if (w_sync) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == LC) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                w_err = (w_sync && !w_slot0) || (i_dat[8] && !w_sync && w_slot0);
                if (w_err) begin
                    if (w_miss_last) begin
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else begin
                        w_miss_nxt = r_miss + 4'd1;
                    end
                end else if (w_sync && w_slot0) begin
                    w_miss_nxt = '0;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    assign o_slot      = r_slot;
    assign o_locked    = (r_state == LOCKED);
    assign o_err       = w_err;
    assign o_miss_last = w_miss_last;

endmodule

// File: rtl/demux_lanes_rx.sv
// Serial 9-bit word stream to four aligned lanes; optional err_count under DEMUX_ERR_CNT_EN.
// Latency: slot-3 word on its lane 1 cycle after sampling, slot-0 word 4 cycles after.
// Backpressure: none; a quad is strobed every 4 cycles while locked, never partially.
module demux_lanes_rx
    import demux_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int          LOCK_COUNT = 4,
    parameter int          MISS_LIMIT = 3
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [8:0]  data_in,
    output logic [8:0]  data0,
    output logic [8:0]  data1,
    output logic [8:0]  data2,
    output logic [8:0]  data3,
    output logic        out_strobe,
    output logic        locked
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    logic [SLOT_W-1:0] w_slot;
    logic              w_locked;
    logic              w_err;
    logic              w_miss_last;
    logic              w_drop;
    logic [8:0]        r_stg0;
    logic [8:0]        r_stg1;
    logic [8:0]        r_stg2;
    logic [8:0]        r_data0;
    logic [8:0]        r_data1;
    logic [8:0]        r_data2;
    logic [8:0]        r_data3;
    logic              r_strobe;
    logic              r_full;

    lane_aligner #(
        .SYNC_BYTE  (SYNC_BYTE),
        .LOCK_COUNT (LOCK_COUNT),
        .MISS_LIMIT (MISS_LIMIT)
    ) u_aligner (
        .i_clk       (clk_4f),
        .i_rst_n     (reset),
        .i_dat       (data_in),
        .o_slot      (w_slot),
        .o_locked    (w_locked),
        .o_err       (w_err),
        .o_miss_last (w_miss_last)
    );

    // The error that exhausts the miss budget also cancels the quad in flight.
    assign w_drop = w_err && w_miss_last;

    // Staging and lane outputs; r_full marks a quad whose slot 0 was captured while locked.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_stg0   <= '0;
            r_stg1   <= '0;
            r_stg2   <= '0;
            r_data0  <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
            r_data3  <= '0;
            r_strobe <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_locked) begin
                case (w_slot)
                    2'd0: begin
                        r_stg0 <= data_in;
                        r_full <= 1'b1;
                    end
                    2'd1: r_stg1 <= data_in;
                    2'd2: r_stg2 <= data_in;
                    default: begin
                        r_full <= 1'b0;
                        if (r_full && !w_drop) begin
                            r_data0  <= lane_word(r_stg0, r_data0[7:0]);
                            r_data1  <= lane_word(r_stg1, r_data1[7:0]);
                            r_data2  <= lane_word(r_stg2, r_data2[7:0]);
                            r_data3  <= lane_word(data_in, r_data3[7:0]);
                            r_strobe <= 1'b1;
                        end
                    end
                endcase
            end else begin
                r_full <= 1'b0;
            end
        end
    end

    assign data0      = r_data0;
    assign data1      = r_data1;
    assign data2      = r_data2;
    assign data3      = r_data3;
    assign out_strobe = r_strobe;
    assign locked     = w_locked;

`ifdef DEMUX_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of misalignment errors seen while locked.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

endmodule
